// File: rtl/pnl_pkg.sv
// pnl_pkg: shared PNL BRAM geometry and the arbiter state encoding.
package pnl_pkg;
    localparam int PNL_BRAM_ADDR_SIZE_NB   = 15;
    localparam int PN__NB                  = 12;
    localparam int PN_PRECISION_NB         = 4;
    localparam int PN_SIZE_NB              = PN__NB + PN_PRECISION_NB;
    localparam int PNL_BRAM_DBITS_WIDTH_NB = PN_SIZE_NB;
    typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder, first set request at or above i_rr_ptr with wrap.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_rr_ptr,
    output logic [N-1:0]         o_pick,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int W = $clog2(N);
    logic [W-1:0] w_j;
    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        o_pick = '0;
        o_idx  = '0;
        o_any  = |i_req;
        w_j    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = W'((int'(i_rr_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_pick      = '0;
                o_pick[w_j] = 1'b1;
                o_idx       = w_j;
            end
        end
    end
endmodule

// File: rtl/pnl_bram_arbiter.sv
// pnl_bram_arbiter: round-robin owner of the single PNL BRAM port, with a sticky hold watchdog.
module pnl_bram_arbiter
    import pnl_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 65535
) (
    input  logic                                                 clk,
    input  logic                                                 reset_n,
    input  logic [NUM_REQ-1:0]                                   req,
    input  logic [NUM_REQ-1:0][PNL_BRAM_ADDR_SIZE_NB-1:0]        req_addr,
    input  logic [NUM_REQ-1:0][PNL_BRAM_DBITS_WIDTH_NB-1:0]      req_din,
    input  logic [NUM_REQ-1:0]                                   req_we,
    output logic [NUM_REQ-1:0]                                   grant,
    output logic [$clog2(NUM_REQ)-1:0]                           grant_id,
    output logic                                                 busy,
    output logic                                                 err_timeout,
    output logic [PNL_BRAM_ADDR_SIZE_NB-1:0]                     PNL_BRAM_addr,
    output logic [PNL_BRAM_DBITS_WIDTH_NB-1:0]                   PNL_BRAM_din,
    output logic                                                 PNL_BRAM_we,
    input  logic [PNL_BRAM_DBITS_WIDTH_NB-1:0]                   PNL_BRAM_dout
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(HOLD_MAX + 1);

    arb_state_t          r_state, w_state_nx;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nx, w_pick;
    logic [IW-1:0]       r_grant_id, w_id_nx, r_rr_ptr, w_ptr_nx, w_pick_idx;
    logic                r_busy, w_busy_nx, r_err, w_err_nx, w_any;
    logic [HW-1:0]       r_hold_cnt, w_hold_nx, w_hold_inc;
    logic                w_unused;

    assign w_unused = ^PNL_BRAM_dout;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_pick   (w_pick),
        .o_idx    (w_pick_idx),
        .o_any    (w_any)
    );

    assign w_hold_inc = (r_hold_cnt == HW'(HOLD_MAX)) ? r_hold_cnt : r_hold_cnt + 1'b1;

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_id_nx    = r_grant_id;
        w_busy_nx  = r_busy;
        w_ptr_nx   = r_rr_ptr;
        w_hold_nx  = r_hold_cnt;
        w_err_nx   = r_err;
        case (r_state)
            IDLE: if (w_any) begin
                w_grant_nx = w_pick;
                w_id_nx    = w_pick_idx;
                w_busy_nx  = 1'b1;
                w_state_nx = GRANTED;
            end
            GRANTED: if (req[r_grant_id]) begin
                w_hold_nx = w_hold_inc;
                w_err_nx  = r_err | (w_hold_inc == HW'(HOLD_MAX));
            end else begin
                w_grant_nx = '0;
                w_busy_nx  = 1'b0;
                w_ptr_nx   = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
                w_hold_nx  = '0;
                w_state_nx = RELEASE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_grant_id <= w_id_nx;
            r_busy     <= w_busy_nx;
            r_rr_ptr   <= w_ptr_nx;
            r_hold_cnt <= w_hold_nx;
            r_err      <= w_err_nx;
        end
    end

    // Zero-latency mux: the owner sees the BRAM exactly as if directly wired.
    assign grant         = r_grant;
    assign grant_id      = r_grant_id;
    assign busy          = r_busy;
    assign err_timeout   = r_err;
    assign PNL_BRAM_addr = r_busy ? req_addr[r_grant_id] : '0;
    assign PNL_BRAM_din  = r_busy ? req_din[r_grant_id] : '0;
    assign PNL_BRAM_we   = r_busy & req_we[r_grant_id] & r_grant[r_grant_id];
endmodule

// File: tb/tb_pnl_bram_arbiter.sv
// tb_pnl_bram_arbiter: directed checks of grant order, mux isolation, watchdog and reset.
module tb_pnl_bram_arbiter;
    import pnl_pkg::*;
    localparam int NR = 4;
    localparam int AW = PNL_BRAM_ADDR_SIZE_NB;
    localparam int DW = PNL_BRAM_DBITS_WIDTH_NB;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NR-1:0]          req, req_we;
    logic [NR-1:0][AW-1:0]  req_addr;
    logic [NR-1:0][DW-1:0]  req_din;
    logic [NR-1:0]          grant;
    logic [1:0]             grant_id;
    logic                   busy, err_timeout, PNL_BRAM_we;
    logic [AW-1:0]          PNL_BRAM_addr;
    logic [DW-1:0]          PNL_BRAM_din, PNL_BRAM_dout;

    int n_pass = 0, n_chk = 0, n_fail = 0, cyc = 0;
    int exp_g[$], obs_g[$];
    logic [AW+DW-1:0] exp_w[$], obs_w[$];
    logic [NR-1:0] prev_g = '0;

    always #5 clk = ~clk;

    pnl_bram_arbiter #(.NUM_REQ(NR), .HOLD_MAX(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_din(req_din),
        .req_we(req_we), .grant(grant), .grant_id(grant_id), .busy(busy),
        .err_timeout(err_timeout), .PNL_BRAM_addr(PNL_BRAM_addr), .PNL_BRAM_din(PNL_BRAM_din),
        .PNL_BRAM_we(PNL_BRAM_we), .PNL_BRAM_dout(PNL_BRAM_dout)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (grant != '0 && prev_g == '0) obs_g.push_back(int'(grant_id));
        prev_g <= grant;
        if (PNL_BRAM_we) obs_w.push_back({PNL_BRAM_addr, PNL_BRAM_din});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int order[5] = '{0, 1, 3, 0, 1};
        int prev = 0;
        reset_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_din = '0; PNL_BRAM_dout = '0;
        step(3); settle();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_addr", 64'(PNL_BRAM_addr), 64'd0);
        chk("rst_din", 64'(PNL_BRAM_din), 64'd0);
        chk("rst_we", 64'(PNL_BRAM_we), 64'd0);

        // Contention: 1011 from reset release, each owner holds 4 cycles then re-raises in RELEASE.
        reset_n = 1'b1; req = 4'b1011;
        foreach (order[i]) exp_g.push_back(order[i]);
        for (int n = 0; n < 5; n++) begin
            int w = 0;
            while (grant == '0 && w < 10) begin step(1); w++; end
            chk("cont_wait", 64'(w < 10), 64'd1);
            chk("cont_id", 64'(grant_id), 64'(order[n]));
            chk("cont_onehot", 64'(grant), 64'(1 << order[n]));
            if (n > 0) chk("cont_gap", 64'(cyc - prev), 64'd6);
            prev = cyc;
            step(3);
            if (n < 4) begin
                req[order[n]] = 1'b0; step(1); req[order[n]] = 1'b1;
            end else begin
                req = '0; step(1);
            end
            settle();
            chk("cont_rel", 64'({busy, grant}), 64'd0);
        end
        step(3);

        // Single requester on lane 2.
        req[2] = 1'b1; exp_g.push_back(2);
        step(1); settle();
        chk("single_grant", 64'(grant), 64'b0100);
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_id", 64'(grant_id), 64'd2);
        step(1);
        req_addr[2] = 15'h0100; req_din[2] = 16'h1234; req_we[2] = 1'b1;
        exp_w.push_back({15'h0100, 16'h1234});
        settle();
        chk("single_addr", 64'(PNL_BRAM_addr), 64'h0100);
        chk("single_din", 64'(PNL_BRAM_din), 64'h1234);
        chk("single_we", 64'(PNL_BRAM_we), 64'd1);
        step(1); req_we[2] = 1'b0; settle();
        chk("single_we_off", 64'(PNL_BRAM_we), 64'd0);
        step(1); req[2] = 1'b0; settle();
        chk("single_hold", 64'(grant), 64'b0100);
        step(1); settle();
        chk("single_rel", 64'({busy, grant}), 64'd0);
        chk("single_lastid", 64'(grant_id), 64'd2);
        step(3);

        // Isolation: lane 0 writes to 0x7FFF while lane 1 owns the port.
        req[1] = 1'b1; exp_g.push_back(1);
        step(1); settle();
        chk("iso_grant", 64'(grant), 64'b0010);
        step(1);
        req_addr[0] = 15'h7FFF; req_din[0] = 16'hDEAD; req_we[0] = 1'b1;
        req_addr[1] = 15'h0055; req_din[1] = 16'hBEEF;
        settle();
        chk("iso_we0", 64'(PNL_BRAM_we), 64'd0);
        chk("iso_addr0", 64'(PNL_BRAM_addr), 64'h0055);
        step(1); req_we[1] = 1'b1; exp_w.push_back({15'h0055, 16'hBEEF}); settle();
        chk("iso_we1", 64'(PNL_BRAM_we), 64'd1);
        chk("iso_addr1", 64'(PNL_BRAM_addr), 64'h0055);
        chk("iso_din1", 64'(PNL_BRAM_din), 64'hBEEF);
        step(1); req_we = '0; req[1] = 1'b0;
        step(3);

        // Watchdog: lane 0 holds the grant for 40 cycles with HOLD_MAX=16.
        settle();
        chk("wd_pre", 64'(err_timeout), 64'd0);
        req[0] = 1'b1; exp_g.push_back(0);
        step(1);
        for (int k = 0; k < 40; k++) begin
            settle();
            chk("wd_grant", 64'(grant), 64'b0001);
            chk("wd_err", 64'(err_timeout), 64'(k >= 16));
            if (k == 39) req[0] = 1'b0;
            step(1);
        end
        settle();
        chk("wd_rel", 64'(grant), 64'd0);
        chk("wd_sticky", 64'(err_timeout), 64'd1);
        step(3); settle();
        chk("wd_sticky2", 64'(err_timeout), 64'd1);

        // Reset in the middle of lane 3's grant.
        step(1);
        req[3] = 1'b1; exp_g.push_back(3);
        step(1); settle();
        chk("mr_grant", 64'(grant), 64'b1000);
        step(2);
        req = 4'b1111; req_addr[3] = 15'h0333; req_din[3] = 16'h3333; req_we[3] = 1'b1; reset_n = 1'b0;
        exp_w.push_back({15'h0333, 16'h3333});
        settle();
        chk("mr_we_pre", 64'(PNL_BRAM_we), 64'd1);
        step(1); settle();
        chk("mr_grant0", 64'(grant), 64'd0);
        chk("mr_busy0", 64'(busy), 64'd0);
        chk("mr_we0", 64'(PNL_BRAM_we), 64'd0);
        chk("mr_id0", 64'(grant_id), 64'd0);
        chk("mr_err0", 64'(err_timeout), 64'd0);
        reset_n = 1'b1; req_we[3] = 1'b0; exp_g.push_back(0);
        step(1); settle();
        chk("mr_first", 64'(grant), 64'b0001);
        req = '0;
        step(4);

        // Idle: lanes drive junk with no request; the BRAM side must stay quiet.
        for (int l = 0; l < NR; l++) begin
            req_addr[l] = AW'(15'h1111 * (l + 1));
            req_din[l]  = DW'(16'h2222 * (l + 1));
        end
        req_we = '1;
        for (int k = 0; k < 20; k++) begin
            step(1); settle();
            chk("idle_out", 64'({busy, PNL_BRAM_we, PNL_BRAM_addr, PNL_BRAM_din}), 64'd0);
        end
        req_we = '0;
        step(2);

        chk("sb_grant_cnt", 64'(obs_g.size()), 64'(exp_g.size()));
        while (exp_g.size() > 0 && obs_g.size() > 0)
            chk("sb_grant", 64'(obs_g.pop_front()), 64'(exp_g.pop_front()));
        chk("sb_write_cnt", 64'(obs_w.size()), 64'(exp_w.size()));
        while (exp_w.size() > 0 && obs_w.size() > 0)
            chk("sb_write", 64'(obs_w.pop_front()), 64'(exp_w.pop_front()));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
